// File: rtl/pkt_header_deparser.sv
`default_nettype none
// ============================================================================
// Module      : pkt_header_deparser
// Description : Egress deparser. Pairs a parsed header vector (PHV) with its
//               buffered packet, writes the PHV containers back into the first
//               two 32-byte beats as directed by the five PHV actions, and
//               emits the rebuilt packet on an AXI Stream master through a
//               single output register stage (latency 1, full throughput).
// Ports       : clk, reset                 - clock, synchronous active-high reset
//               phv_in/phv_valid/phv_ready - PHV from fallthrough FIFO
//               s_axis_*                   - packet from fallthrough FIFO
//               m_axis_*                   - rebuilt packet to output queues
//               deparsed_pkt_cnt           - packets emitted since reset
// Revision    : 1.0 - initial release
// ============================================================================
module pkt_header_deparser #(
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int PKT_VEC_WIDTH        = 1124
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [PKT_VEC_WIDTH-1:0]          phv_in,
    input  logic                              phv_valid,
    output logic                              phv_ready,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                              s_axis_tlast,
    input  logic                              s_axis_tvalid,
    output logic                              s_axis_tready,
    output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                              m_axis_tlast,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic [31:0]                       deparsed_pkt_cnt
);

    localparam int C_LANES = C_S_AXIS_DATA_WIDTH / 8;

    localparam logic [1:0] S_WAIT_PHV = 2'd0;
    localparam logic [1:0] S_BEAT0    = 2'd1;
    localparam logic [1:0] S_BEAT1    = 2'd2;
    localparam logic [1:0] S_FLUSH    = 2'd3;

    logic [1:0]                        r_state;
    logic [1:0]                        w_next_state;
    logic [PKT_VEC_WIDTH-1:0]          r_phv;
    logic                              w_accept;
    logic [C_S_AXIS_DATA_WIDTH-1:0]    w_tdata;
    logic [C_S_AXIS_TUSER_WIDTH-1:0]   w_tuser;
    logic                              w_unused_phv;

    // Returns the byte for packet offset k after applying every valid action
    // in order, so a later action overwrites an earlier one on shared bytes.
    // The container is shifted left so its byte at distance rel from the MSB
    // lands in the top byte (network order).
    function automatic logic [7:0] f_patch_byte(
        input logic [PKT_VEC_WIDTH-1:0] phv,
        input logic [5:0]               k,
        input logic [7:0]               orig
    );
        logic [7:0]  b;
        logic [5:0]  off;
        logic [1:0]  typ;
        logic [2:0]  idx;
        logic [5:0]  rel;
        logic [15:0] sh2;
        logic [31:0] sh4;
        logic [47:0] sh6;
        b = orig;
        for (int j = 0; j < 5; j++) begin
            off = phv[256 + 20*j + 14 +: 6];
            typ = phv[256 + 20*j + 12 +: 2];
            idx = phv[256 + 20*j + 9  +: 3];
            rel = k - off;
            sh2 = phv[356 + 16*idx +: 16] << {rel[0],   3'b000};
            sh4 = phv[484 + 32*idx +: 32] << {rel[1:0], 3'b000};
            sh6 = phv[740 + 48*idx +: 48] << {rel[2:0], 3'b000};
            if (k >= off) begin
                case (typ)
                    2'b01:   if (rel < 6'd2) b = sh2[15:8];
                    2'b10:   if (rel < 6'd4) b = sh4[31:24];
                    2'b11:   if (rel < 6'd6) b = sh6[47:40];
                    default: b = b;
                endcase
            end
        end
        return b;
    endfunction

    assign w_accept      = s_axis_tvalid && s_axis_tready;
    assign s_axis_tready = (r_state != S_WAIT_PHV) && (!m_axis_tvalid || m_axis_tready);
    // A PHV is only taken together with the start of its packet.
    assign phv_ready     = !reset && (r_state == S_WAIT_PHV) && phv_valid && s_axis_tvalid;

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_WAIT_PHV: if (phv_ready) w_next_state = S_BEAT0;
            S_BEAT0:    if (w_accept)  w_next_state = s_axis_tlast ? S_WAIT_PHV : S_BEAT1;
            S_BEAT1:    if (w_accept)  w_next_state = s_axis_tlast ? S_WAIT_PHV : S_FLUSH;
            S_FLUSH:    if (w_accept && s_axis_tlast) w_next_state = S_WAIT_PHV;
            default:    w_next_state = S_WAIT_PHV;
        endcase
    end

    // Patched beat: beat 0 covers offsets 0..31, beat 1 covers 32..63.
    always_comb begin
        w_tdata = s_axis_tdata;
        w_tuser = s_axis_tuser;
        if (r_state == S_BEAT0 || r_state == S_BEAT1) begin
            for (int l = 0; l < C_LANES; l++) begin
                w_tdata[8*l +: 8] = f_patch_byte(r_phv, {r_state == S_BEAT1, 5'(l)},
                                                 s_axis_tdata[8*l +: 8]);
            end
        end
        if (r_state == S_BEAT0) begin
            w_tuser[31:24] = r_phv[31:24];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= S_WAIT_PHV;
            r_phv            <= '0;
            m_axis_tvalid    <= 1'b0;
            m_axis_tdata     <= '0;
            m_axis_tkeep     <= '0;
            m_axis_tuser     <= '0;
            m_axis_tlast     <= 1'b0;
            deparsed_pkt_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            if (phv_ready) begin
                r_phv <= phv_in;
            end
            if (w_accept) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= w_tdata;
                m_axis_tkeep  <= s_axis_tkeep;
                m_axis_tuser  <= w_tuser;
                m_axis_tlast  <= s_axis_tlast;
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
            if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
                deparsed_pkt_cnt <= deparsed_pkt_cnt + 32'd1;
            end
        end
    end

    // Metadata other than the destination port and the reserved action bits
    // are carried in the PHV but have no role in deparsing.
    assign w_unused_phv = ^{r_phv[255:32], r_phv[23:0],
                            r_phv[256 +: 9], r_phv[276 +: 9], r_phv[296 +: 9],
                            r_phv[316 +: 9], r_phv[336 +: 9]};

endmodule
`default_nettype wire

// File: tb/tb_pkt_header_deparser.sv
`default_nettype none
// ============================================================================
// Module      : tb_pkt_header_deparser
// Description : Self-checking bench for pkt_header_deparser. Packets and PHVs
//               are checked against a byte-array reference model of the patch
//               rules; directed cases plus randomized packets.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pkt_header_deparser;

    localparam int PW = 1124;

    typedef struct packed {
        logic [255:0] d;
        logic [31:0]  k;
        logic [127:0] u;
        logic         l;
    } beat_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [PW-1:0] phv_in;
    logic          phv_valid;
    logic          phv_ready;
    logic [255:0]  s_axis_tdata;
    logic [31:0]   s_axis_tkeep;
    logic [127:0]  s_axis_tuser;
    logic          s_axis_tlast;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic [255:0]  m_axis_tdata;
    logic [31:0]   m_axis_tkeep;
    logic [127:0]  m_axis_tuser;
    logic          m_axis_tlast;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b1;
    logic [31:0]   deparsed_pkt_cnt;

    pkt_header_deparser dut (
        .clk              (clk),
        .reset            (reset),
        .phv_in           (phv_in),
        .phv_valid        (phv_valid),
        .phv_ready        (phv_ready),
        .s_axis_tdata     (s_axis_tdata),
        .s_axis_tkeep     (s_axis_tkeep),
        .s_axis_tuser     (s_axis_tuser),
        .s_axis_tlast     (s_axis_tlast),
        .s_axis_tvalid    (s_axis_tvalid),
        .s_axis_tready    (s_axis_tready),
        .m_axis_tdata     (m_axis_tdata),
        .m_axis_tkeep     (m_axis_tkeep),
        .m_axis_tuser     (m_axis_tuser),
        .m_axis_tlast     (m_axis_tlast),
        .m_axis_tvalid    (m_axis_tvalid),
        .m_axis_tready    (m_axis_tready),
        .deparsed_pkt_cnt (deparsed_pkt_cnt)
    );

    always #5 clk = ~clk;

    beat_t        exp_q[$];
    bit           rdy_q[$];
    logic [255:0] tx_d[4];
    logic [31:0]  tx_k[4];
    logic [127:0] tx_u[4];
    int           errors = 0;
    int           checks = 0;
    int           pkts_exp = 0;
    bit           mon_en = 1'b1;
    bit           rdy_rand = 1'b0;

    task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic void model_push(input logic [PW-1:0] phv, input int nb);
        logic [7:0]  pb[128];
        logic [47:0] c;
        int          off, n, idx, k;
        beat_t       bt;
        for (int i = 0; i < nb*32; i++) pb[i] = tx_d[i/32][8*(i%32) +: 8];
        for (int j = 0; j < 5; j++) begin
            off = int'(phv[256 + 20*j + 14 +: 6]);
            n   = 2 * int'(phv[256 + 20*j + 12 +: 2]);
            idx = int'(phv[256 + 20*j + 9 +: 3]);
            c   = '0;
            if (n == 2) c = 48'(phv[356 + 16*idx +: 16]);
            if (n == 4) c = 48'(phv[484 + 32*idx +: 32]);
            if (n == 6) c = phv[740 + 48*idx +: 48];
            for (int r = 0; r < n; r++) begin
                k = off + r;
                if (k < 64 && k < nb*32) pb[k] = c[8*(n-1-r) +: 8];
            end
        end
        for (int b = 0; b < nb; b++) begin
            for (int i = 0; i < 32; i++) bt.d[8*i +: 8] = pb[32*b + i];
            bt.k = tx_k[b];
            bt.u = tx_u[b];
            if (b == 0) bt.u[31:24] = phv[31:24];
            bt.l = (b == nb - 1);
            exp_q.push_back(bt);
        end
        pkts_exp++;
    endfunction

    // ---------------- PHV construction helpers ----------------
    function automatic logic [PW-1:0] set_act(input logic [PW-1:0] p, input int j,
                                              input int off, input int typ, input int idx);
        logic [5:0] o;
        logic [1:0] t;
        logic [2:0] x;
        o = off[5:0]; t = typ[1:0]; x = idx[2:0];
        p[256 + 20*j +: 20] = {o, t, x, 9'h0};
        return p;
    endfunction

    function automatic logic [PW-1:0] rand_phv();
        logic [PW-1:0] p;
        p = '0;
        for (int i = 0; i < 35; i++) p[32*i +: 32] = $urandom;
        p[1123:1120] = 4'($urandom);
        return p;
    endfunction

    task automatic gen_tx(input int nb, input bit zero);
        for (int b = 0; b < 4; b++) begin
            tx_d[b] = '0;
            if (!zero) for (int i = 0; i < 8; i++) tx_d[b][32*i +: 32] = $urandom;
            tx_k[b] = (b == nb - 1) ? ($urandom | 32'h1) : 32'hFFFF_FFFF;
            tx_u[b] = {$urandom, $urandom, $urandom, $urandom};
        end
    endtask

    // ---------------- driver ----------------
    task automatic send_pkt(input logic [PW-1:0] phv, input int nb, input bit bubbles);
        int b = 0;
        int guard = 0;
        int taken_n = 0;
        bit hs, taken;
        model_push(phv, nb);
        phv_in    = phv;
        phv_valid = 1'b1;
        if (bubbles && ($urandom % 3 == 0)) begin
            s_axis_tvalid = 1'b0;
            repeat (2) begin
                @(negedge clk);
                chk("phv_ready_no_pkt", 256'(phv_ready), 256'(0));
                @(posedge clk); #1;
            end
        end
        while (b < nb && guard < 300) begin
            s_axis_tdata  = tx_d[b];
            s_axis_tkeep  = tx_k[b];
            s_axis_tuser  = tx_u[b];
            s_axis_tlast  = (b == nb - 1);
            s_axis_tvalid = bubbles ? ($urandom % 4 != 0) : 1'b1;
            @(negedge clk);
            taken = phv_valid && phv_ready;
            hs    = s_axis_tvalid && s_axis_tready;
            if (!phv_valid && phv_ready) taken_n++;
            @(posedge clk); #1;
            if (taken) begin
                phv_valid = 1'b0;
                taken_n++;
            end
            if (hs) b++;
            guard++;
        end
        s_axis_tvalid = 1'b0;
        chk("send_done", 256'(b), 256'(nb));
        chk("phv_once", 256'(taken_n), 256'(1));
    endtask

    task automatic wait_drain();
        int g = 0;
        while (exp_q.size() != 0 && g < 400) begin
            @(posedge clk); #1;
            g++;
        end
        chk("drain", 256'(exp_q.size()), 256'(0));
        repeat (2) @(posedge clk);
        #1;
        chk("pkt_cnt", 256'(deparsed_pkt_cnt), 256'(pkts_exp));
    endtask

    // ---------------- downstream ready ----------------
    initial begin
        forever begin
            @(posedge clk); #1;
            if (rdy_q.size() != 0) m_axis_tready = rdy_q.pop_front();
            else                   m_axis_tready = rdy_rand ? ($urandom % 3 != 0) : 1'b1;
        end
    end

    // ---------------- output monitor ----------------
    initial begin
        beat_t held, cur, e;
        bit    hold_chk = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en && !reset) begin
                cur = '{m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast};
                if (hold_chk) begin
                    chk("stall_valid", 256'(m_axis_tvalid), 256'(1));
                    chk("stall_hold", 256'(cur.d ^ held.d) | 256'(cur.u ^ held.u), 256'(0));
                end
                if (m_axis_tvalid && m_axis_tready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", 256'(1), 256'(0));
                    end else begin
                        e = exp_q.pop_front();
                        chk("tdata", cur.d, e.d);
                        chk("tkeep", 256'(cur.k), 256'(e.k));
                        chk("tuser", 256'(cur.u), 256'(e.u));
                        chk("tlast", 256'(cur.l), 256'(e.l));
                    end
                end
                hold_chk = m_axis_tvalid && !m_axis_tready;
                held     = cur;
            end else begin
                hold_chk = 1'b0;
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [PW-1:0] p;
        int            g;
        reset         = 1'b1;
        phv_in        = '0;
        phv_valid     = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tuser  = '0;
        s_axis_tlast  = 1'b0;
        s_axis_tvalid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_m_tvalid", 256'(m_axis_tvalid), 256'(0));
        chk("rst_m_tdata", m_axis_tdata, 256'(0));
        chk("rst_cnt", 256'(deparsed_pkt_cnt), 256'(0));
        chk("rst_s_tready", 256'(s_axis_tready), 256'(0));
        chk("rst_phv_ready", 256'(phv_ready), 256'(0));
        @(posedge clk); #1;
        reset = 1'b0;

        // 3-beat zero packet, EtherType-like 2B patch at offset 12
        gen_tx(3, 1'b1);
        p = '0;
        p[356 +: 16] = 16'h0800;
        p = set_act(p, 0, 12, 1, 0);
        send_pkt(p, 3, 1'b0);
        wait_drain();

        // 6B patch straddling the beat0/beat1 boundary
        gen_tx(2, 1'b0);
        p = '0;
        p[740 + 48*2 +: 48] = 48'h1122_3344_5566;
        p = set_act(p, 1, 30, 3, 2);
        send_pkt(p, 2, 1'b0);
        wait_drain();

        // overlapping 4B patches (later action wins) and truncation past offset 63
        gen_tx(3, 1'b0);
        p = '0;
        p[484 +: 32]      = 32'hAAAA_AAAA;
        p[484 + 32 +: 32] = 32'hBBBB_BBBB;
        p[740 + 48*5 +: 48] = 48'hC1C2_C3C4_C5C6;
        p = set_act(p, 0, 20, 2, 0);
        p = set_act(p, 3, 20, 2, 1);
        p = set_act(p, 4, 62, 3, 5);
        send_pkt(p, 3, 1'b0);
        wait_drain();

        // single-beat packet with a patch beyond tlast, then back-to-back packet
        gen_tx(1, 1'b0);
        p = rand_phv();
        p = set_act(p, 2, 40, 2, 3);
        send_pkt(p, 1, 1'b0);
        gen_tx(2, 1'b0);
        send_pkt(rand_phv(), 2, 1'b0);
        wait_drain();

        // downstream stalls during a 4-beat packet, dst port in tuser
        gen_tx(4, 1'b0);
        p = rand_phv();
        p[31:24] = 8'h04;
        rdy_q = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        send_pkt(p, 4, 1'b0);
        wait_drain();

        // reset in BEAT1 aborts the packet
        gen_tx(3, 1'b0);
        phv_in        = rand_phv();
        phv_valid     = 1'b1;
        s_axis_tdata  = tx_d[0];
        s_axis_tkeep  = tx_k[0];
        s_axis_tuser  = tx_u[0];
        s_axis_tlast  = 1'b0;
        s_axis_tvalid = 1'b1;
        g = 0;
        forever begin
            @(negedge clk);
            if (s_axis_tready || g >= 20) break;
            @(posedge clk); #1;
            if (phv_valid && !phv_ready) phv_valid = phv_valid;
            g++;
        end
        chk("abort_beat0_ready", 256'(s_axis_tready), 256'(1));
        @(posedge clk); #1;
        phv_valid     = 1'b0;
        s_axis_tvalid = 1'b0;
        mon_en        = 1'b0;
        reset         = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort_m_tvalid", 256'(m_axis_tvalid), 256'(0));
        chk("abort_cnt", 256'(deparsed_pkt_cnt), 256'(0));
        chk("abort_s_tready", 256'(s_axis_tready), 256'(0));
        exp_q.delete();
        pkts_exp = 0;
        @(posedge clk); #1;
        reset  = 1'b0;
        mon_en = 1'b1;
        gen_tx(3, 1'b0);
        send_pkt(rand_phv(), 3, 1'b0);
        wait_drain();

        // randomized packets, bubbles and downstream backpressure
        rdy_rand = 1'b1;
        for (int n = 0; n < 30; n++) begin
            int nb;
            nb = 1 + int'($urandom % 4);
            gen_tx(nb, 1'b0);
            send_pkt(rand_phv(), nb, 1'b1);
        end
        wait_drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
